// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB next-PC predictor with 2-bit counters.
// Define BTB_GSHARE_EN for a GHR-indexed pattern history table.
module branch_predictor_btb #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 32,
  parameter int HIST_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      pc,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      next_pc,
  output logic [HIST_BITS-1:0] pred_ghr,
  input  logic                 update_valid,
  input  logic [XLEN-1:0]      update_pc,
  input  logic                 update_is_branch,
  input  logic                 update_taken,
  input  logic [XLEN-1:0]      update_target,
  input  logic [HIST_BITS-1:0] update_ghr
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic            valid_q [ENTRIES];
  logic [TAGW-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0] tgt_q   [ENTRIES];
  logic            jmp_q   [ENTRIES];

  function automatic logic [1:0] sat_upd(
    input logic [1:0] c,
    input logic       t
  );
    logic [1:0] r;
    if (t) r = (c == 2'b11) ? c : c + 2'd1;
    else   r = (c == 2'b00) ? c : c - 2'd1;
    return r;
  endfunction

  logic [IDX-1:0]  l_idx;
  logic [TAGW-1:0] l_tag;
  logic            l_hit;
  logic [1:0]      l_ctr;

  logic [IDX-1:0]  u_idx;
  logic [TAGW-1:0] u_tag;
  logic            u_hit;
  logic            ent_we;
  logic            jmp_d;

  assign l_idx = pc[IDX+1:2];
  assign l_tag = pc[XLEN-1:IDX+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  assign u_idx = update_pc[IDX+1:2];
  assign u_tag = update_pc[XLEN-1:IDX+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Jumps always (re)allocate; branches only write the entry when taken.
  assign ent_we = update_valid && (!update_is_branch || update_taken);
  assign jmp_d  = update_is_branch ? (u_hit && jmp_q[u_idx]) : 1'b1;

  assign pred_taken = l_hit && (jmp_q[l_idx] || l_ctr[1]);
  assign next_pc    = pred_taken ? tgt_q[l_idx] : pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        jmp_q[i]   <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else if (ent_we) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx]   <= u_tag;
      tgt_q[u_idx]   <= update_target;
      jmp_q[u_idx]   <= jmp_d;
    end
  end

`ifdef BTB_GSHARE_EN

  logic [1:0]           pht_q [ENTRIES];
  logic [HIST_BITS-1:0] ghr_q;
  logic [HIST_BITS-1:0] ghr_d;
  logic [HIST_BITS:0]   ghr_sh;
  logic [IDX-1:0]       p_idx;
  logic [1:0]           pht_d;
  logic                 pht_we;
  logic                 unused_bits;

  assign l_ctr    = pht_q[l_idx ^ IDX'(ghr_q)];
  assign pred_ghr = ghr_q;

  assign pht_we = update_valid && update_is_branch;
  assign p_idx  = u_idx ^ IDX'(update_ghr);
  assign pht_d  = sat_upd(pht_q[p_idx], update_taken);
  assign ghr_sh = {ghr_q, update_taken};
  assign ghr_d  = ghr_sh[HIST_BITS-1:0];

  assign unused_bits = ^{pc[1:0], update_pc[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= 2'b01;
      end
    end else if (pht_we) begin
      ghr_q        <= ghr_d;
      pht_q[p_idx] <= pht_d;
    end
  end

`else

  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] ctr_d;
  logic       ctr_we;
  logic       unused_bits;

  assign l_ctr    = ctr_q[l_idx];
  assign pred_ghr = '0;

  // Miss-and-taken allocation starts at weak taken.
  assign ctr_we = update_valid && update_is_branch
               && (u_hit || update_taken);
  assign ctr_d  = u_hit ? sat_upd(ctr_q[u_idx], update_taken)
                        : 2'b10;

  assign unused_bits = ^{pc[1:0], update_pc[1:0], update_ghr};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (ctr_we) begin
      ctr_q[u_idx] <= ctr_d;
    end
  end

`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed vector table,
// multi-cycle sequences and random traffic against a reference model.
module tb_branch_predictor_btb;

`ifdef BTB_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] next_pc;
  logic [4:0]  pred_ghr;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_is_branch;
  logic        update_taken;
  logic [31:0] update_target;
  logic [4:0]  update_ghr;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor_btb dut (
    .clk              (clk),
    .reset            (reset),
    .pc               (pc),
    .pred_taken       (pred_taken),
    .next_pc          (next_pc),
    .pred_ghr         (pred_ghr),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_is_branch (update_is_branch),
    .update_taken     (update_taken),
    .update_target    (update_target),
    .update_ghr       (update_ghr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_valid [32];
  int m_tag   [32];
  int m_tgt   [32];
  int m_jmp   [32];
  int m_ctr   [32];
  int m_pht   [32];
  int m_ghr;

  function automatic int sat(input int c, input bit t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 0; m_jmp[i] = 0; m_ctr[i] = 1; m_pht[i] = 1;
      m_tag[i] = 0; m_tgt[i] = 0;
    end
    m_ghr = 0;
  endfunction

  function automatic void m_predict(input logic [31:0] p,
                                    output bit t,
                                    output logic [31:0] n,
                                    output logic [31:0] g);
    int i;
    int c;
    bit hit;
    i   = int'((p / 4) % 32);
    hit = (m_valid[i] != 0) && (m_tag[i] == int'(p / 128));
    c   = GS ? m_pht[i ^ m_ghr] : m_ctr[i];
    t   = hit && (m_jmp[i] != 0 || c >= 2);
    n   = t ? m_tgt[i] : p + 32'd4;
    g   = GS ? m_ghr : 0;
  endfunction

  function automatic void m_update(input logic [31:0] up, input bit br,
                                   input bit tk, input logic [31:0] tg,
                                   input int gh);
    int i;
    bit hit;
    i   = int'((up / 4) % 32);
    hit = (m_valid[i] != 0) && (m_tag[i] == int'(up / 128));
    if (br) begin
      if (GS) begin
        m_pht[i ^ gh] = sat(m_pht[i ^ gh], tk);
        m_ghr = ((m_ghr * 2) + int'(tk)) % 32;
      end else if (hit) begin
        m_ctr[i] = sat(m_ctr[i], tk);
      end else if (tk) begin
        m_ctr[i] = 2;
      end
      if (hit && tk) m_tgt[i] = tg;
      if (!hit && tk) begin
        m_valid[i] = 1; m_tag[i] = int'(up / 128);
        m_tgt[i] = tg; m_jmp[i] = 0;
      end
    end else begin
      m_valid[i] = 1; m_tag[i] = int'(up / 128);
      m_tgt[i] = tg; m_jmp[i] = 1;
    end
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        br;
    logic        tk;
    logic [31:0] tgt;
    logic        exp_t;
    logic [31:0] exp_n;
  } vec_t;

  vec_t vt[$];

  task automatic drive(input logic r, input logic [31:0] p,
                       input logic uv, input logic [31:0] upc,
                       input logic br, input logic tk,
                       input logic [31:0] tg, input logic [4:0] gh);
    reset = r; pc = p; update_valid = uv; update_pc = upc;
    update_is_branch = br; update_taken = tk;
    update_target = tg; update_ghr = gh;
  endtask

  task automatic do_reset();
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit          et;
    logic [31:0] en;
    logic [31:0] eg;

    drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

`ifndef BTB_GSHARE_EN
    // {rst, pc, uv, upc, br, tk, tgt, exp_taken, exp_next}
    vt.push_back('{0, 32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 32'h44});
    vt.push_back('{0, 32'h40, 1, 32'h40, 1, 1, 32'h100, 0, 32'h44});
    vt.push_back('{0, 32'h40, 1, 32'h40, 1, 0, 32'h0,   1, 32'h100});
    vt.push_back('{0, 32'h40, 1, 32'h40, 1, 0, 32'h0,   0, 32'h44});
    vt.push_back('{0, 32'h40, 1, 32'h40, 1, 1, 32'h100, 0, 32'h44});
    vt.push_back('{0, 32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 32'h44});
    vt.push_back('{0, 32'h40, 1, 32'h40, 1, 1, 32'h100, 0, 32'h44});
    vt.push_back('{0, 32'h40, 1, 32'h40, 1, 1, 32'h100, 1, 32'h100});
    vt.push_back('{0, 32'h40, 1, 32'h40, 1, 1, 32'h100, 1, 32'h100});
    vt.push_back('{0, 32'h40, 1, 32'h40, 1, 1, 32'h100, 1, 32'h100});
    vt.push_back('{0, 32'h40, 1, 32'h40, 1, 0, 32'h0,   1, 32'h100});
    vt.push_back('{0, 32'h40, 0, 32'h0,  0, 0, 32'h0,   1, 32'h100});
    vt.push_back('{0, 32'hC0, 0, 32'h0,  0, 0, 32'h0,   0, 32'hC4});
    vt.push_back('{0, 32'hC0, 1, 32'hC0, 1, 1, 32'h200, 0, 32'hC4});
    vt.push_back('{0, 32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 32'h44});
    vt.push_back('{0, 32'hC0, 0, 32'h0,  0, 0, 32'h0,   1, 32'h200});
    vt.push_back('{0, 32'h80, 1, 32'h80, 0, 1, 32'h300, 0, 32'h84});
    vt.push_back('{0, 32'h80, 0, 32'h0,  0, 0, 32'h0,   1, 32'h300});
    vt.push_back('{0, 32'h80, 1, 32'h80, 1, 0, 32'h0,   1, 32'h300});
    vt.push_back('{0, 32'h80, 0, 32'h0,  0, 0, 32'h0,   1, 32'h300});
    vt.push_back('{1, 32'hC0, 1, 32'hC0, 1, 1, 32'h400, 1, 32'h200});
    vt.push_back('{0, 32'hC0, 0, 32'h0,  0, 0, 32'h0,   0, 32'hC4});
    vt.push_back('{0, 32'h80, 0, 32'h0,  0, 0, 32'h0,   0, 32'h84});
    vt.push_back('{0, 32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 32'h44});
    vt.push_back('{0, 32'hFFFFFFFC, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0});

    check("reset pred_ghr", 32'(pred_ghr), 32'h0);
    for (int k = 0; k < vt.size(); k++) begin
      drive(vt[k].rst, vt[k].pc, vt[k].uv, vt[k].upc,
            vt[k].br, vt[k].tk, vt[k].tgt, 5'h0);
      @(negedge clk);
      check($sformatf("vec[%0d] pred_taken", k),
            32'(pred_taken), 32'(vt[k].exp_t));
      check($sformatf("vec[%0d] next_pc", k), next_pc, vt[k].exp_n);
      @(posedge clk); #1;
    end
`else
    // history after T,T,NT
    check("reset pred_ghr", 32'(pred_ghr), 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 32'h40, 1, 32'h40, 1, (k < 2), 32'h100, pred_ghr);
      @(posedge clk); #1;
    end
    drive(0, 32'h40, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("ghr after T,T,NT", 32'(pred_ghr), 32'h06);
    @(posedge clk); #1;

    // alternating branch learned through history
    do_reset();
    for (int k = 0; k < 40; k++) begin
      drive(0, 32'h40, 1, 32'h40, 1, (k % 2 == 0), 32'h100, 0);
      @(negedge clk);
      update_ghr = pred_ghr;
      if (k >= 12) begin
        check($sformatf("alt[%0d] pred_taken", k),
              32'(pred_taken), 32'(k % 2 == 0));
        check($sformatf("alt[%0d] next_pc", k), next_pc,
              (k % 2 == 0) ? 32'h100 : 32'h44);
      end
      @(posedge clk); #1;
    end
`endif

    // ---------------- random traffic vs model ----------------
    do_reset();
    m_reset();
    for (int k = 0; k < 1500; k++) begin
      logic [31:0] rp;
      logic [31:0] up;
      logic [31:0] tl [4];
      bit          br;
      bit          tk;
      bit          uv;
      bit          rs;
      logic [31:0] tg;
      int          gh;
      tl[0] = 0; tl[1] = 1; tl[2] = 2; tl[3] = 32'h1FFFFFF;
      rp = (tl[$urandom_range(0, 3)] << 7)
         | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      up = (tl[$urandom_range(0, 3)] << 7)
         | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      uv = ($urandom_range(0, 1) == 1);
      br = ($urandom_range(0, 3) != 0);
      tk = br ? ($urandom_range(0, 1) == 1) : 1'b1;
      tg = $urandom & 32'hFFFFFFFC;
      gh = $urandom_range(0, 31);
      rs = ($urandom_range(0, 99) == 0);
      drive(rs, rp, uv, up, br, tk, tg, 5'(gh));
      @(negedge clk);
      m_predict(rp, et, en, eg);
      check($sformatf("rnd[%0d] pred_taken", k), 32'(pred_taken), 32'(et));
      check($sformatf("rnd[%0d] next_pc", k), next_pc, en);
      check($sformatf("rnd[%0d] pred_ghr", k), 32'(pred_ghr), eg);
      @(posedge clk); #1;
      if (rs) m_reset();
      else if (uv) m_update(up, br, tk, tg, gh);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised next-PC predictor for the 5-stage RISC-V pipeline; replaces the fixed "current_pc + 4" next-PC logic in IF.
- A direct-mapped branch target buffer with per-entry 2-bit saturating counters supplies a predicted next PC each cycle.
- The EX stage reports resolved control-flow outcomes back through an update port; misprediction detection and flush stay outside this block.

Parameters:
- XLEN, 32, PC/target width in bits.
- ENTRIES, 32, BTB entries; power of 2, >= 2. IDX = log2(ENTRIES).
- HIST_BITS, 5, global history length; 1 <= HIST_BITS <= IDX. Used only with GSHARE_EN.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- pc  in  XLEN  current IF-stage PC.
- pred_taken  out  1  lookup predicts redirect.
- next_pc  out  XLEN  predicted next PC: stored target if pred_taken, else pc+4.
- pred_ghr  out  HIST_BITS  history snapshot at lookup; pipelined alongside the instruction.
- update_valid  in  1  one resolved control-flow instruction this cycle.
- update_pc  in  XLEN  PC of the resolved instruction.
- update_is_branch  in  1  1 = conditional branch, 0 = JAL/JALR.
- update_taken  in  1  actual direction (always 1 for jumps).
- update_target  in  XLEN  actual target.
- update_ghr  in  HIST_BITS  pred_ghr value that travelled with this instruction.

Behaviour:
- Entry fields: valid, tag = pc[XLEN-1:IDX+2], target[XLEN], is_jump, ctr[1:0].
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Lookup is combinational, 0-cycle latency. idx = pc[IDX+1:2]. hit = valid & tag match.
- pred_taken = hit & (is_jump | ctr[1]).
- next_pc = pred_taken ? target : pc+4. pc+4 is computed mod 2^XLEN.
- Update is registered and visible to lookups from the next cycle. There is no same-cycle bypass: a lookup to the index being written sees the old contents.
- Branch update, hit: ctr saturating increment if taken, saturating decrement if not taken. If taken, target <= update_target.
- Branch update, miss and taken: allocate/replace the entry with valid=1, new tag, target, is_jump=0, ctr=10.
- Branch update, miss and not taken: no change.
- Jump update: allocate or overwrite with valid=1, tag, target, is_jump=1. ctr is left unchanged.
- update_pc[1:0] is ignored. At most one update per cycle.
- Reset: all valid=0, ctr=01, is_jump=0, GHR=0. Hence pred_taken=0 and next_pc=pc+4 in the cycle after reset.
- Reset asserted mid-operation discards any simultaneous update.

Optional Feature:
- Macro: BTB_GSHARE_EN.
- When defined:
  - A separate pattern history table of ENTRIES 2-bit counters (reset 01) replaces the per-entry ctr for conditional-branch direction.
  - Lookup uses PHT[idx ^ zero_ext(GHR)]; update uses PHT[update_idx ^ zero_ext(update_ghr)].
  - The PHT is updated on every branch update, hit or miss.
  - GHR <= {GHR[HIST_BITS-2:0], update_taken} on each branch update; jumps do not shift it. GHR is nonspeculative.
  - pred_ghr = GHR.
- When undefined:
  - Per-entry counters as above.
  - No GHR register; pred_ghr = 0 and update_ghr is ignored.

Test Plan (defaults, macro off unless noted; idx = pc[6:2]):
- Reset, then pc=0x40 -> pred_taken=0, next_pc=0x44.
- Branch update pc=0x40, taken, target=0x100; next cycle pc=0x40 -> pred_taken=1, next_pc=0x100. Two NT updates -> ctr=00, next_pc=0x44. One T update -> ctr=01, still 0x44.
- Four T updates at 0x40 -> ctr=11; one NT -> ctr=10, still predicts 0x100. Same-cycle lookup of 0x40 during an update sees the pre-update prediction.
- Alias: entry at 0x40 valid; pc=0xC0 (same idx, different tag) -> next_pc=0xC4. Taken update at 0xC0 with target 0x200 replaces the entry; pc=0x40 -> 0x44, pc=0xC0 -> 0x200.
- Jump update pc=0x80, target 0x300 -> pc=0x80 predicts 0x300 regardless of ctr. Then assert reset for one cycle with a simultaneous update -> all lookups miss, pc+4.
- BTB_GSHARE_EN: branch pc=0x40 alternating T/NT with update_ghr fed from pred_ghr -> after warm-up, 100% correct prediction. pred_ghr after updates T,T,NT = 5'b00110.
